iccm_arbiter: RTL and testbench

ICCM_ARBITER -- requirements
Module: iccm_arbiter

---
 rtl/iccm_arb_pkg.sv | 20 ++
 rtl/iccm_arb_grant.sv | 117 +++++++++++
 rtl/iccm_arbiter.sv | 88 ++++++++
 tb/tb_iccm_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iccm_arb_pkg.sv
// Shared widths, response-owner encoding and small helpers for the ICCM arbiter.
// The ICCM_ARB_RR_EN build option is consumed by iccm_arb_grant.
package iccm_arb_pkg;

    localparam int ICCM_AW = 12;
    localparam int ICCM_DW = 32;
    localparam int ICCM_BW = 4;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        HOST  = 2'd2
    } rsp_owner_e;

    // A host access returns data only when no byte lane is written.
    function automatic logic is_host_read(input logic h_gnt, input logic [ICCM_BW-1:0] we);
        return h_gnt && (we == {ICCM_BW{1'b0}});
    endfunction

endpackage

// File: rtl/iccm_arb_grant.sv
// Grant selection between the fetch and host ports.
// Default: fetch priority with host starvation limit; `define ICCM_ARB_RR_EN for round-robin.
module iccm_arb_grant
    import iccm_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic f_req,
    input  logic h_req,
    output logic f_gnt,
    output logic h_gnt
);

`ifdef ICCM_ARB_RR_EN

    // Set when host won the most recent grant; reset value makes fetch win first.
    logic last_host_q;
    logic last_host_d;

    // Combinational grant: sole requester wins, contention goes to the less recent winner.
    always_comb begin
        f_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!rst_ni) begin
            f_gnt = 1'b0;
        end else if (f_req && h_req) begin
            if (last_host_q) begin
                f_gnt = 1'b1;
            end else begin
                h_gnt = 1'b1;
            end
        end else if (f_req) begin
            f_gnt = 1'b1;
        end else if (h_req) begin
            h_gnt = 1'b1;
        end else begin
            f_gnt = 1'b0;
        end
    end

    // Remember which port was granted last; idle cycles keep the history.
    always_comb begin
        last_host_d = last_host_q;
        if (h_gnt) begin
            last_host_d = 1'b1;
        end else if (f_gnt) begin
            last_host_d = 1'b0;
        end else begin
            last_host_d = last_host_q;
        end
    end

    // Round-robin history register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_host_q <= 1'b1;
        end else begin
            last_host_q <= last_host_d;
        end
    end

`else

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] wait_q;
    logic [7:0] wait_d;

    // Combinational grant: fetch wins contention until host has waited LIMIT cycles.
    always_comb begin
        f_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!rst_ni) begin
            f_gnt = 1'b0;
        end else if (f_req && h_req) begin
            if (wait_q == LIMIT) begin
                h_gnt = 1'b1;
            end else begin
                f_gnt = 1'b1;
            end
        end else if (f_req) begin
            f_gnt = 1'b1;
        end else if (h_req) begin
            h_gnt = 1'b1;
        end else begin
            f_gnt = 1'b0;
        end
    end

    // Saturating count of cycles host has been kept waiting.
    always_comb begin
        wait_d = 8'd0;
        if (h_req && !h_gnt) begin
            if (wait_q == LIMIT) begin
                wait_d = wait_q;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end else begin
            wait_d = 8'd0;
        end
    end

    // Host wait counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end

`endif

endmodule

// File: rtl/iccm_arbiter.sv
// Two-port (fetch read-only, host read/write) arbiter in front of a 1-cycle ICCM.
// Grant policy lives in iccm_arb_grant; ICCM_ARB_RR_EN selects round-robin there.
module iccm_arbiter
    import iccm_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               f_req,
    input  logic [ICCM_AW-1:0] f_addr,
    output logic [ICCM_DW-1:0] f_rdata,
    output logic               f_gnt,
    output logic               f_rvalid,
    input  logic               h_req,
    input  logic [ICCM_AW-1:0] h_addr,
    input  logic [ICCM_DW-1:0] h_wdata,
    input  logic [ICCM_BW-1:0] h_we,
    output logic               h_gnt,
    output logic [ICCM_DW-1:0] h_rdata,
    output logic               h_rvalid,
    output logic               mem_req,
    output logic [ICCM_AW-1:0] mem_addr,
    output logic [ICCM_DW-1:0] mem_wdata,
    output logic [ICCM_BW-1:0] mem_we,
    input  logic [ICCM_DW-1:0] mem_rdata,
    input  logic               mem_rvalid
);

    rsp_owner_e owner_q;
    rsp_owner_e owner_d;

    iccm_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .f_req  (f_req),
        .h_req  (h_req),
        .f_gnt  (f_gnt),
        .h_gnt  (h_gnt)
    );

    assign mem_req = f_gnt | h_gnt;

    // Request mux: fetch never writes, and an idle bus is driven to zero.
    always_comb begin
        mem_addr  = {ICCM_AW{1'b0}};
        mem_wdata = {ICCM_DW{1'b0}};
        mem_we    = {ICCM_BW{1'b0}};
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (h_gnt) begin
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
            mem_we    = h_we;
        end else begin
            mem_addr = {ICCM_AW{1'b0}};
        end
    end

    // Owner of the response that returns next cycle; host writes expect none.
    always_comb begin
        owner_d = NONE;
        if (f_gnt) begin
            owner_d = FETCH;
        end else if (is_host_read(h_gnt, h_we)) begin
            owner_d = HOST;
        end else begin
            owner_d = NONE;
        end
    end

    // Response owner register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_q <= NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign f_rvalid = mem_rvalid && (owner_q == FETCH);
    assign h_rvalid = mem_rvalid && (owner_q == HOST);
    assign f_rdata  = (owner_q == FETCH) ? mem_rdata : {ICCM_DW{1'b0}};
    assign h_rdata  = (owner_q == HOST)  ? mem_rdata : {ICCM_DW{1'b0}};

endmodule

// File: tb/tb_iccm_arbiter.sv
// Self-checking bench for iccm_arbiter: directed scenarios plus random traffic,
// checked against a cycle-level reference model and a behavioural ICCM stand-in.
module tb_iccm_arbiter;

    localparam int unsigned LIMIT = 8;

    logic        clk_i;
    logic        rst_ni;
    logic        f_req;
    logic [11:0] f_addr;
    logic [31:0] f_rdata;
    logic        f_gnt;
    logic        f_rvalid;
    logic        h_req;
    logic [11:0] h_addr;
    logic [31:0] h_wdata;
    logic [3:0]  h_we;
    logic        h_gnt;
    logic [31:0] h_rdata;
    logic        h_rvalid;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    iccm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_rdata   (f_rdata),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .h_req     (h_req),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_we      (h_we),
        .h_gnt     (h_gnt),
        .h_rdata   (h_rdata),
        .h_rvalid  (h_rvalid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] pat(input logic [11:0] a);
        return {a ^ 12'hA5C, 4'h3, ~a, 4'h9};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ICCM stand-in: answers every access one cycle later (writes too, so the
    // arbiter must filter them), unwritten words read back as pat(addr).
    logic [31:0] smem [4096];
    bit          swr  [4096];
    always @(posedge clk_i) begin
        mem_rvalid <= mem_req;
        mem_rdata  <= swr[mem_addr] ? smem[mem_addr] : pat(mem_addr);
        if (mem_req && (mem_we != 4'h0)) begin
            smem[mem_addr] <= merge(swr[mem_addr] ? smem[mem_addr] : pat(mem_addr), mem_wdata, mem_we);
            swr[mem_addr]  <= 1'b1;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [4096];
    bit          ref_wr  [4096];
    int          host_waited = 0;
    bit          host_won_last = 1'b1;
    bit          pend_f = 1'b0;
    bit          pend_h = 1'b0;
    logic [31:0] pend_data = 32'h0;
    logic        obs_fg;
    logic        obs_hg;

    function automatic logic [31:0] ref_rd(input logic [11:0] a);
        return ref_wr[a] ? ref_mem[a] : pat(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic fr, input logic [11:0] fa,
                        input logic hr, input logic [11:0] ha, input logic [31:0] hwd,
                        input logic [3:0] hwe);
        bit efg;
        bit ehg;
        @(negedge clk_i);
        rst_ni = rst; f_req = fr; f_addr = fa; h_req = hr; h_addr = ha; h_wdata = hwd; h_we = hwe;
        #1;
        efg = 1'b0;
        ehg = 1'b0;
        if (rst) begin
            if (fr && hr) begin
`ifdef ICCM_ARB_RR_EN
                if (host_won_last) efg = 1'b1; else ehg = 1'b1;
`else
                if (host_waited >= int'(LIMIT)) ehg = 1'b1; else efg = 1'b1;
`endif
            end else begin
                efg = fr;
                ehg = hr;
            end
        end
        obs_fg = f_gnt;
        obs_hg = h_gnt;
        chk("f_gnt", f_gnt, efg);
        chk("h_gnt", h_gnt, ehg);
        chk("mem_req", mem_req, efg | ehg);
        chk("mem_addr", mem_addr, efg ? fa : (ehg ? ha : 12'h0));
        chk("mem_we", mem_we, ehg ? hwe : 4'h0);
        chk("mem_wdata", mem_wdata, ehg ? hwd : 32'h0);
        chk("f_rvalid", f_rvalid, pend_f);
        chk("h_rvalid", h_rvalid, pend_h);
        if (pend_f) begin
            chk("f_rdata", f_rdata, pend_data);
            chk("h_rdata_idle", h_rdata, 32'h0);
        end
        if (pend_h) begin
            chk("h_rdata", h_rdata, pend_data);
            chk("f_rdata_idle", f_rdata, 32'h0);
        end
        // Advance model to the next cycle.
        pend_f    = efg;
        pend_h    = ehg && (hwe == 4'h0);
        pend_data = efg ? ref_rd(fa) : ref_rd(ha);
        if (ehg && hwe != 4'h0) begin
            ref_mem[ha] = merge(ref_rd(ha), hwd, hwe);
            ref_wr[ha]  = 1'b1;
        end
        if (!rst) begin
            host_waited   = 0;
            host_won_last = 1'b1;
        end else begin
            if (hr && !ehg) host_waited = (host_waited + 1 > int'(LIMIT)) ? int'(LIMIT) : host_waited + 1;
            else            host_waited = 0;
            if (efg) host_won_last = 1'b0;
            if (ehg) host_won_last = 1'b1;
        end
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 4'h0);
    endtask

    initial begin
        rst_ni = 1'b0; f_req = 1'b0; f_addr = 12'h0; h_req = 1'b0; h_addr = 12'h0;
        h_wdata = 32'h0; h_we = 4'h0;
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);

        // Fetch read with one-cycle latency.
        step(1'b1, 1'b1, 12'h010, 1'b0, 12'h0, 32'h0, 4'h0);
        chk("fetch_gnt_same_cycle", obs_fg, 1'b1);
        idle(1'b1);

        // Host write then read-back; the write yields no rvalid.
        step(1'b1, 1'b0, 12'h0, 1'b1, 12'h020, 32'hDEADBEEF, 4'hF);
        step(1'b1, 1'b0, 12'h0, 1'b1, 12'h020, 32'h0, 4'h0);
        idle(1'b1);
        chk("readback_word", ref_rd(12'h020), 32'hDEADBEEF);

        // Alternating sole requesters, no bubbles.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b1, 12'h100, 1'b0, 12'h0, 32'h0, 4'h0);
            else            step(1'b1, 1'b0, 12'h0, 1'b1, 12'h200, 32'h0, 4'h0);
        end
        idle(1'b1);

`ifdef ICCM_ARB_RR_EN
        idle(1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 12'h040, 1'b1, 12'h044, 32'h0, 4'h0);
            chk("rr_fgnt", obs_fg, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr_hgnt", obs_hg, (i % 2 == 1) ? 1'b1 : 1'b0);
        end
        idle(1'b1);
`else
        // Contention: eight fetch grants then a forced host grant.
        for (int i = 0; i < int'(LIMIT) + 1; i++) begin
            step(1'b1, 1'b1, 12'h040, 1'b1, 12'h044, 32'h0, 4'h0);
            chk("starve_fgnt", obs_fg, (i < int'(LIMIT)) ? 1'b1 : 1'b0);
        end
        @(posedge clk_i);
        #1;
        chk("wait_cleared", 32'(dut.u_grant.wait_q), 32'h0);
        idle(1'b1);
`endif

        // Reset asserted while fetch requests: no grant, no rvalid afterwards.
        step(1'b1, 1'b1, 12'h080, 1'b0, 12'h0, 32'h0, 4'h0);
        step(1'b0, 1'b1, 12'h084, 1'b0, 12'h0, 32'h0, 4'h0);
        chk("rst_no_gnt", obs_fg, 1'b0);
        idle(1'b1);
        step(1'b1, 1'b1, 12'h088, 1'b1, 12'h08C, 32'h0, 4'h0);
        chk("post_rst_fetch_first", obs_fg, 1'b1);

        // Random traffic over a small address window with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic        fr;
            logic        hr;
            logic [3:0]  we;
            r  = ($urandom_range(0, 59) != 0);
            fr = ($urandom_range(0, 3) != 0);
            hr = ($urandom_range(0, 2) != 0);
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            step(r, fr, 12'($urandom_range(0, 15) * 4), hr, 12'($urandom_range(0, 15) * 4),
                 $urandom, we);
        end
        idle(1'b1);
        idle(1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
